// File: rtl/mips16_pkg.sv
// Shared MIPS16 pipeline definitions: default widths, the hard-wired zero register
// and the write-back queue entry layout.
package mips16_pkg;
    localparam int MIPS_DATA_W     = 16;
    localparam int MIPS_REG_ADDR_W = 3;
    localparam int REG_ZERO        = 0;

    typedef struct packed {
        logic [MIPS_REG_ADDR_W-1:0] rd;
        logic [MIPS_DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Generic DEPTH x W FIFO with synchronous flush, occupancy count and a tap on the
// raw storage array plus read pointer so a caller can search live entries.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 19
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           push,
    input  logic [W-1:0]                   wdata,
    input  logic                           pop,
    output logic [W-1:0]                   rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH):0]         count,
    output logic [$clog2(DEPTH)-1:0]       rd_ptr,
    output logic [DEPTH-1:0][W-1:0]        tap
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic                    do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign tap     = mem;

    // flush wins over any push/pop presented in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/write_back_queue.sv
// MIPS16 write-back stage: result mux, enqueue filter, pending-write FIFO, retired value.
// Build with WB_FORWARD_EN defined to add the decode-stage bypass search.
module write_back_queue
    import mips16_pkg::*;
#(
    parameter int DATA_W     = MIPS_DATA_W,
    parameter int REG_ADDR_W = MIPS_REG_ADDR_W,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data_alu,
    input  logic [DATA_W-1:0]       in_data_mem,
    input  logic                    in_sel_mem,
    input  logic                    in_wr_en,
    input  logic [REG_ADDR_W-1:0]   in_rd,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
    input  logic                    rf_ack,
    output logic [DATA_W-1:0]       ans_wb,
    output logic [$clog2(DEPTH):0]  wb_count,
    input  logic [REG_ADDR_W-1:0]   fwd_raddr,
    output logic                    fwd_hit,
    output logic [DATA_W-1:0]       fwd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = REG_ADDR_W + DATA_W;

    logic [DEPTH-1:0][EW-1:0] tap;
    logic [EW-1:0]            head;
    logic [AW-1:0]            rd_ptr;
    logic                     full, empty, push, pop;
    logic [DATA_W-1:0]        result;

    assign in_ready = !full && !flush;
    assign result   = in_sel_mem ? in_data_mem : in_data_alu;
    // beats that do not write a real register are consumed without touching the queue
    assign push     = in_valid && in_ready && in_wr_en && (in_rd != REG_ADDR_W'(REG_ZERO));
    assign pop      = rf_ack;

    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .push   (push),
        .wdata  ({in_rd, result}),
        .pop    (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .count  (wb_count),
        .rd_ptr (rd_ptr),
        .tap    (tap)
    );

    assign rf_we    = !empty;
    assign rf_waddr = head[EW-1:DATA_W];
    assign rf_wdata = head[DATA_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ans_wb <= '0;
        else if (rf_we && rf_ack && !flush)
            ans_wb <= rf_wdata;
    end

`ifdef WB_FORWARD_EN
    logic [AW-1:0] idx;

    // walk oldest to youngest so the last match left standing is the youngest
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if ((($clog2(DEPTH)+1)'(i) < wb_count) &&
                (tap[idx][EW-1:DATA_W] == fwd_raddr) &&
                (fwd_raddr != REG_ADDR_W'(REG_ZERO))) begin
                fwd_hit  = 1'b1;
                fwd_data = tap[idx][DATA_W-1:0];
            end
        end
    end
`else
    logic unused_fwd;

    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
    assign unused_fwd = ^{fwd_raddr, rd_ptr, tap};
`endif
endmodule
